// File: rtl/lock_guard_ctrl.sv
// Lock front-end controller: debounced command pulses,
// failed-attempt counting, timed lockout and alarm.
module lock_guard_ctrl #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int MAX_FAILS    = 3,
  parameter int LOCKOUT_SEC  = 30,
  parameter int MAX_LOCKOUTS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ent_raw,
  input  logic       clr_raw,
  input  logic       change_raw,
  input  logic       try_valid,
  input  logic       try_match,
  output logic       ent_p,
  output logic       clr_p,
  output logic       change_p,
  output logic       lockout,
  output logic       alarm,
  output logic       blink,
  output logic [2:0] fail_cnt,
  output logic [5:0] remain_sec
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {
    READY,
    COOLDOWN,
    ALARM
  } state_t;

  state_t        state;
  logic [1:0]    lock_cnt;
  logic [PW-1:0] pre_cnt;
  logic          wrap;
  logic          sec_tick;
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    lvl;
  logic [2:0]    rise;
  logic [2:0]    pend;
  logic [2:0]    grant;
  logic [DW-1:0] db_cnt [3];

  assign wrap     = (pre_cnt == PW'(TICK_DIV - 1));
  assign sec_tick = wrap & blink;

  // Free-running half-second prescaler driving blink
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
      blink   <= 1'b0;
    end else if (wrap) begin
      pre_cnt <= '0;
      blink   <= ~blink;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Bit order: 0 = clr, 1 = ent, 2 = change
  assign raw = {change_raw, ent_raw, clr_raw};

  // Accepted level is about to go 0->1
  always_comb begin
    rise = '0;
    for (int i = 0; i < 3; i++) begin
      rise[i] = sync2[i] & ~lvl[i] &
                (db_cnt[i] == DW'(DEBOUNCE_CYC - 1));
    end
  end

  // Synchronise and debounce each button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
          lvl[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Fixed priority: clr over ent over change
  always_comb begin
    grant = '0;
    if (pend[0]) begin
      grant = 3'b001;
    end else if (pend[1]) begin
      grant = 3'b010;
    end else if (pend[2]) begin
      grant = 3'b100;
    end
  end

  // Pending flags and one registered pulse per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      clr_p    <= 1'b0;
      ent_p    <= 1'b0;
      change_p <= 1'b0;
    end else if (state != READY) begin
      pend     <= '0;
      clr_p    <= 1'b0;
      ent_p    <= 1'b0;
      change_p <= 1'b0;
    end else begin
      pend     <= (pend & ~grant) | rise;
      clr_p    <= grant[0];
      ent_p    <= grant[1];
      change_p <= grant[2];
    end
  end

  // Attempt counting, lockout timer and alarm
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= READY;
      fail_cnt   <= '0;
      lock_cnt   <= '0;
      remain_sec <= '0;
      lockout    <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      unique case (state)
        READY: begin
          if (try_valid) begin
            if (try_match) begin
              fail_cnt <= '0;
              lock_cnt <= '0;
            end else if (fail_cnt == 3'(MAX_FAILS - 1)) begin
              fail_cnt <= 3'(MAX_FAILS);
              lockout  <= 1'b1;
              if (lock_cnt == 2'(MAX_LOCKOUTS - 1)) begin
                state <= ALARM;
                alarm <= 1'b1;
              end else begin
                state      <= COOLDOWN;
                remain_sec <= 6'(LOCKOUT_SEC);
                lock_cnt   <= lock_cnt + 1'b1;
              end
            end else begin
              fail_cnt <= fail_cnt + 1'b1;
            end
          end
        end
        COOLDOWN: begin
          if (sec_tick) begin
            if (remain_sec == 6'd1) begin
              state      <= READY;
              fail_cnt   <= '0;
              remain_sec <= '0;
              lockout    <= 1'b0;
            end else begin
              remain_sec <= remain_sec - 1'b1;
            end
          end
        end
        ALARM: begin
          lockout <= 1'b1;
          alarm   <= 1'b1;
        end
        default: begin
          state <= READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_guard_ctrl.sv
// Directed bench for lock_guard_ctrl with small
// timing parameters and hand-computed expectations.
module tb_lock_guard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ent_raw = 1'b0;
  logic       clr_raw = 1'b0;
  logic       change_raw = 1'b0;
  logic       try_valid = 1'b0;
  logic       try_match = 1'b0;
  logic       ent_p;
  logic       clr_p;
  logic       change_p;
  logic       lockout;
  logic       alarm;
  logic       blink;
  logic [2:0] fail_cnt;
  logic [5:0] remain_sec;

  int n_vec = 0;
  int n_err = 0;
  int ne, nc, nh, te, tc, th;
  int t2, t1, t0, ok, n;
  logic b0;

  lock_guard_ctrl #(
    .TICK_DIV    (10),
    .DEBOUNCE_CYC(4),
    .MAX_FAILS   (3),
    .LOCKOUT_SEC (3),
    .MAX_LOCKOUTS(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ent_raw   (ent_raw),
    .clr_raw   (clr_raw),
    .change_raw(change_raw),
    .try_valid (try_valid),
    .try_match (try_match),
    .ent_p     (ent_p),
    .clr_p     (clr_p),
    .change_p  (change_p),
    .lockout   (lockout),
    .alarm     (alarm),
    .blink     (blink),
    .fail_cnt  (fail_cnt),
    .remain_sec(remain_sec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got,
                       input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_cnt();
    ne = 0; nc = 0; nh = 0;
    te = 0; tc = 0; th = 0;
  endtask

  task automatic run(input int k);
    for (int i = 1; i <= k; i++) begin
      @(posedge clk);
      #1;
      if (ent_p) begin ne++; te = i; end
      if (clr_p) begin nc++; tc = i; end
      if (change_p) begin nh++; th = i; end
    end
  endtask

  task automatic try_code(input logic m);
    try_valid = 1'b1;
    try_match = m;
    step(1);
    try_valid = 1'b0;
    try_match = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    t2 = -1; t1 = -1; t0 = -1; ok = 0;
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk);
      #1;
      if (remain_sec == 6'd2 && t2 < 0) t2 = i;
      if (remain_sec == 6'd1 && t1 < 0) t1 = i;
      if (!lockout) begin
        t0 = i;
        ok = 1;
        break;
      end
    end
    check({tag, "_done"}, ok, 1);
    check({tag, "_gap32"}, t1 - t2, 20);
    check({tag, "_gap21"}, t0 - t1, 20);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_outs"},
          int'({ent_p, clr_p, change_p, lockout,
                alarm, blink}), 0);
    check({tag, "_fail"}, int'(fail_cnt), 0);
    check({tag, "_rem"}, int'(remain_sec), 0);
  endtask

  initial begin
    step(3);
    check_zero("reset");
    rst = 1'b1;
    step(2);

    // blink half period
    b0 = blink;
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (blink != b0) break;
    end
    b0 = blink;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      n++;
      if (blink != b0) break;
    end
    check("blink_half", n, 10);

    // T1 glitch then hold
    clr_cnt();
    ent_raw = 1'b1;
    run(2);
    ent_raw = 1'b0;
    run(8);
    check("t1_glitch", ne, 0);
    clr_cnt();
    ent_raw = 1'b1;
    run(10);
    check("t1_cnt", ne, 1);
    check("t1_lat", te, 7);
    ent_raw = 1'b0;
    run(8);
    check("t1_fall", ne, 1);

    // T2 simultaneous press
    clr_cnt();
    clr_raw = 1'b1;
    ent_raw = 1'b1;
    change_raw = 1'b1;
    run(12);
    check("t2_nclr", nc, 1);
    check("t2_tclr", tc, 7);
    check("t2_nent", ne, 1);
    check("t2_tent", te, 8);
    check("t2_nchg", nh, 1);
    check("t2_tchg", th, 9);
    clr_raw = 1'b0;
    ent_raw = 1'b0;
    change_raw = 1'b0;
    run(8);

    // T3 lockout and countdown
    try_code(1'b0);
    check("t3_f1", int'(fail_cnt), 1);
    try_code(1'b0);
    check("t3_f2", int'(fail_cnt), 2);
    check("t3_lk0", int'(lockout), 0);
    try_code(1'b0);
    check("t3_f3", int'(fail_cnt), 3);
    check("t3_lk1", int'(lockout), 1);
    check("t3_rem", int'(remain_sec), 3);
    check("t3_al0", int'(alarm), 0);
    try_code(1'b1);
    check("t3_ignore", int'(lockout), 1);
    wait_ready("t3");
    check("t3_fc0", int'(fail_cnt), 0);
    check("t3_rem0", int'(remain_sec), 0);

    // T4 match clears failures
    try_code(1'b0);
    try_code(1'b0);
    check("t4_f2", int'(fail_cnt), 2);
    try_code(1'b1);
    check("t4_f0", int'(fail_cnt), 0);
    check("t4_lk", int'(lockout), 0);

    // T5 two lockouts lead to alarm
    repeat (3) try_code(1'b0);
    check("t5_lk1", int'(lockout), 1);
    check("t5_al0", int'(alarm), 0);
    wait_ready("t5");
    repeat (3) try_code(1'b0);
    check("t5_alarm", int'(alarm), 1);
    check("t5_lock", int'(lockout), 1);
    check("t5_fc", int'(fail_cnt), 3);
    check("t5_rem", int'(remain_sec), 0);
    clr_cnt();
    ent_raw = 1'b1;
    clr_raw = 1'b1;
    run(12);
    check("t5_nopulse", ne + nc + nh, 0);
    ent_raw = 1'b0;
    clr_raw = 1'b0;
    try_code(1'b1);
    step(60);
    check("t5_hold", int'(alarm), 1);

    // T6 reset mid-cooldown
    rst = 1'b0;
    step(1);
    check("t6_al_rst", int'(alarm), 0);
    rst = 1'b1;
    step(2);
    repeat (3) try_code(1'b0);
    check("t6_rem3", int'(remain_sec), 3);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (remain_sec == 6'd2) begin
        ok = 1;
        break;
      end
      step(1);
    end
    check("t6_rem2", ok, 1);
    rst = 1'b0;
    #2;
    check_zero("t6_async");
    step(2);
    check_zero("t6_held");
    rst = 1'b1;
    step(1);
    check("t6_lk", int'(lockout), 0);
    clr_cnt();
    ent_raw = 1'b1;
    run(10);
    check("t6_ent", ne, 1);
    check("t6_lat", te, 7);
    ent_raw = 1'b0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
